// File: rtl/vending_alarm_request.sv
// Fault monitor ahead of the buzzer controller: raises start_alarm for a fixed hold, then a low gap.
// Optional macro ALARM_MUTE_EN adds a mute input that gates start_alarm at the output only.
`default_nettype none

module vending_alarm_request #(
    parameter int ALARM_HOLD_S = 4,
    parameter int GAP_S        = 2,
    parameter int TIMEOUT_S    = 10,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sec_tick,
    input  logic             txn_active,
    input  logic             coin_evt,
    input  logic             coin_bad,
    input  logic             sel_evt,
    input  logic             no_stock,
    input  logic             low_funds,
`ifdef ALARM_MUTE_EN
    input  logic             mute,
`endif
    output logic             start_alarm,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] fault_count
);

    localparam int HC_MAX = (ALARM_HOLD_S > GAP_S) ? ALARM_HOLD_S : GAP_S;
    localparam int HC_W   = $clog2(HC_MAX + 1);
    localparam int TM_W   = $clog2(TIMEOUT_S + 1);

    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(ALARM_HOLD_S - 1);
    localparam logic [HC_W-1:0] GAP_LAST  = HC_W'(GAP_S - 1);
    localparam logic [TM_W-1:0] TMO_LAST  = TM_W'(TIMEOUT_S - 1);

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_COIN    = 3'd1;
    localparam logic [2:0] CODE_FUNDS   = 3'd2;
    localparam logic [2:0] CODE_STOCK   = 3'd3;
    localparam logic [2:0] CODE_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [HC_W-1:0] hold_cnt, hold_nxt;
    logic [HC_W-1:0] gap_cnt, gap_nxt;
    logic [2:0]      pend_code, pend_nxt;
    logic [2:0]      code_nxt;
    logic [2:0]      det_code;
    logic [2:0]      merged_code;
    logic            count_inc;
    logic [TM_W-1:0] tmo_cnt;
    logic            tmo_fire;
    logic            activity;
    logic            input_fault;

    assign activity    = coin_evt | sel_evt;
    assign input_fault = coin_bad | low_funds | no_stock;
    assign tmo_fire    = (state == IDLE) && txn_active && sec_tick && !activity
                         && (tmo_cnt == TMO_LAST);

    // Highest-priority fault of this clock; code 0 means nothing detected.
    always_comb begin
        det_code = CODE_NONE;
        if (tmo_fire)       det_code = CODE_TIMEOUT;
        else if (no_stock)  det_code = CODE_STOCK;
        else if (low_funds) det_code = CODE_FUNDS;
        else if (coin_bad)  det_code = CODE_COIN;
    end

    // Pending slot keeps only a strictly higher-priority code; 0 marks the slot empty.
    assign merged_code = (det_code > pend_code) ? det_code : pend_code;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        pend_nxt  = pend_code;
        code_nxt  = fault_code;
        count_inc = 1'b0;
        case (state)
            IDLE: begin
                if (det_code != CODE_NONE) begin
                    code_nxt  = det_code;
                    count_inc = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = ALARM;
                end
            end
            ALARM: begin
                pend_nxt = merged_code;
                if (sec_tick) begin
                    if (hold_cnt == HOLD_LAST) begin
                        gap_nxt   = '0;
                        state_nxt = GAP;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                pend_nxt = merged_code;
                if (sec_tick) begin
                    if (gap_cnt == GAP_LAST) begin
                        if (merged_code != CODE_NONE) begin
                            code_nxt  = merged_code;
                            count_inc = 1'b1;
                            hold_nxt  = '0;
                            pend_nxt  = CODE_NONE;
                            state_nxt = ALARM;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            pend_code   <= CODE_NONE;
            fault_code  <= CODE_NONE;
            fault_count <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            gap_cnt    <= gap_nxt;
            pend_code  <= pend_nxt;
            fault_code <= code_nxt;
            if (count_inc && (fault_count != {CNT_W{1'b1}}))
                fault_count <= fault_count + 1'b1;
        end
    end

    // Idle-transaction timer only counts while IDLE inside an open transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if ((state != IDLE) || !txn_active || activity || input_fault || tmo_fire) begin
            tmo_cnt <= '0;
        end else if (sec_tick) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

`ifdef ALARM_MUTE_EN
    assign start_alarm = (state == ALARM) && !mute;
`else
    assign start_alarm = (state == ALARM);
`endif

endmodule

`default_nettype wire

// File: doc/vending_alarm_request.md
Name: vending_alarm_request

Overview:
- Fault monitor sitting directly upstream of the 3-second buzzer controller. It watches vending transaction events on the system clock and detects faults.
- On a fault it drives the buzzer controller's start_alarm level for a fixed number of 1-second ticks, then holds a mandatory low gap so the buzzer controller re-arms cleanly.
- It latches a fault code and keeps a saturating fault count for the display/debug path.

Parameters:
- ALARM_HOLD_S, 4, seconds start_alarm stays high; 1 tick to arm plus 3 buzzer seconds.
- GAP_S, 2, seconds start_alarm is forced low after a hold, min 1.
- TIMEOUT_S, 10, idle seconds inside an open transaction before a timeout fault.
- CNT_W, 8, fault_count width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sec_tick  in  1  one-clk pulse per second, aligned with the 1-second clock edge.
- txn_active  in  1  high while a purchase is in progress.
- coin_evt  in  1  one-clk pulse, a coin was accepted (activity).
- coin_bad  in  1  one-clk pulse, coin rejected.
- sel_evt  in  1  one-clk pulse, product selected (activity).
- no_stock  in  1  one-clk pulse, selected product empty.
- low_funds  in  1  one-clk pulse, credit below price.
- start_alarm  out  1  level to the buzzer controller.
- fault_code  out  3  last raised fault: 0 none, 1 coin_bad, 2 low_funds, 3 no_stock, 4 timeout.
- fault_count  out  CNT_W  number of faults raised, saturating.

Behaviour:
- Reset (async, any time, including mid-alarm):
  - FSM goes to IDLE.
  - start_alarm=0, fault_code=0, fault_count=0.
  - pending cleared, timers cleared.
- Fault detect, same clk: priority timeout(4) > no_stock(3) > low_funds(2) > coin_bad(1). Only the highest simultaneous fault is kept.
- IDLE:
  - On a detected fault: fault_code <= code, fault_count += 1 (sticks at all-ones), hold_cnt <= 0, go to ALARM.
  - start_alarm rises the clk after the fault pulse (1-clk latency).
- ALARM:
  - start_alarm=1.
  - hold_cnt increments on each sec_tick. When hold_cnt reaches ALARM_HOLD_S-1 and a sec_tick arrives: go to GAP, gap_cnt <= 0, start_alarm drops next clk.
- GAP:
  - start_alarm=0. gap_cnt increments on sec_tick.
  - After GAP_S ticks: if pending is valid, raise it as a new alarm (load fault_code, increment fault_count, go to ALARM, clear pending). Otherwise go to IDLE.
- Faults in ALARM/GAP:
  - Stored in a one-deep pending slot, not counted yet.
  - A higher-priority fault overwrites the pending code; equal or lower is dropped.
- Timeout timer:
  - Runs only while txn_active=1 and FSM is IDLE.
  - Cleared by coin_evt, sel_evt, txn_active=0, or any fault.
  - Increments on sec_tick. Reaching TIMEOUT_S raises fault 4 and clears the timer.
  - The timer does not run during ALARM/GAP.
- fault_code holds its value until the next raised fault or reset.
- Counter widths: hold_cnt/gap_cnt are sized clog2 of max(ALARM_HOLD_S, GAP_S)+1. The timeout counter is sized clog2(TIMEOUT_S+1). No wrap; counters are compared, then cleared.
- sec_tick and a fault in the same clk while IDLE: the fault wins. The tick does not count toward the new hold.

Optional Feature:
- ALARM_MUTE_EN.
- When defined: adds input mute (1 bit). While mute=1, start_alarm is forced 0 at the output. The FSM, fault_code, fault_count and pending run unchanged; muted alarms still complete their hold/gap timing.
- When undefined: no mute port, and start_alarm comes directly from the FSM.

Test Plan:
- Reset, then coin_bad pulse at t0 → start_alarm=1 from t0+1 clk; fault_code=1, fault_count=1; start_alarm stays high for exactly 4 sec_ticks, then low for 2 sec_ticks; FSM back in IDLE.
- coin_bad and no_stock in the same clk → fault_code=3, fault_count=1 (not 2).
- During ALARM: low_funds, then no_stock → after the gap, a second alarm with fault_code=3, fault_count=2; low_funds is never counted.
- txn_active=1 with no activity for 10 sec_ticks → fault_code=4 raised. Repeat with a coin_evt at tick 7 → no timeout until tick 17.
- rst asserted asynchronously mid-ALARM → start_alarm, fault_code, fault_count drop to 0 immediately, without waiting for a clk edge.
- Drive 260 faults (CNT_W=8) spaced past hold+gap → fault_count saturates at 255. With ALARM_MUTE_EN and mute=1 → start_alarm stays 0 while the count increments.
